// File: rtl/zap_tag_ram_ctrl_pkg.sv
// Shared sizing, FSM encoding, pipeline stage record and RAM word helpers
// for the tag RAM controller.
package zap_tag_ram_ctrl_pkg;

  localparam int DEPTH  = 32;
  localparam int TAG_W  = 20;
  localparam int DATA_W = 32;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int RAM_W  = TAG_W + DATA_W;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CLR   = 2'd2,
    ACK   = 2'd3
  } state_t;

  typedef struct packed {
    logic             v;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
  } stage_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } ram_word_t;

  // The tag occupies the MSBs of every stored word.
  function automatic ram_word_t split_word(input logic [RAM_W-1:0] word);
    ram_word_t w;
    w.tag  = word[RAM_W-1:DATA_W];
    w.data = word[DATA_W-1:0];
    return w;
  endfunction

endpackage

// File: rtl/zap_tag_ram_ctrl_if.sv
// Requester and RAM-side signals of the tag RAM controller; the slave
// modport is the controller's view, the master modport the environment's.
interface zap_tag_ram_ctrl_if;
  import zap_tag_ram_ctrl_pkg::*;

  logic              i_lkp_valid;
  logic              o_lkp_ready;
  logic [IDX_W-1:0]  i_lkp_idx;
  logic [TAG_W-1:0]  i_lkp_tag;
  logic              i_wr_valid;
  logic              o_wr_ready;
  logic [IDX_W-1:0]  i_wr_idx;
  logic [TAG_W-1:0]  i_wr_tag;
  logic [DATA_W-1:0] i_wr_data;
  logic              i_inv_req;
  logic              o_inv_ack;
  logic              o_res_valid;
  logic              i_res_ready;
  logic              o_res_hit;
  logic [DATA_W-1:0] o_res_data;
  logic              o_ram_clken;
  logic              o_ram_wen;
  logic              o_ram_inv;
  logic [IDX_W-1:0]  o_ram_raddr;
  logic [IDX_W-1:0]  o_ram_waddr;
  logic [RAM_W-1:0]  o_ram_wdata;
  logic [RAM_W-1:0]  i_ram_rdata;
  logic              i_ram_rdav;

  modport slave (
    input  i_lkp_valid, i_lkp_idx, i_lkp_tag,
    input  i_wr_valid, i_wr_idx, i_wr_tag, i_wr_data,
    input  i_inv_req, i_res_ready, i_ram_rdata, i_ram_rdav,
    output o_lkp_ready, o_wr_ready, o_inv_ack,
    output o_res_valid, o_res_hit, o_res_data,
    output o_ram_clken, o_ram_wen, o_ram_inv,
    output o_ram_raddr, o_ram_waddr, o_ram_wdata
  );

  modport master (
    output i_lkp_valid, i_lkp_idx, i_lkp_tag,
    output i_wr_valid, i_wr_idx, i_wr_tag, i_wr_data,
    output i_inv_req, i_res_ready, i_ram_rdata, i_ram_rdav,
    input  o_lkp_ready, o_wr_ready, o_inv_ack,
    input  o_res_valid, o_res_hit, o_res_data,
    input  o_ram_clken, o_ram_wen, o_ram_inv,
    input  o_ram_raddr, o_ram_waddr, o_ram_wdata
  );

endinterface

// File: rtl/zap_tag_ram_ctrl_pipe.sv
// Two-stage lookup tracker aligned with the RAM read latency; freezes with
// the RAM clock enable and flags refills that hit an in-flight index.
module zap_tag_ram_ctrl_pipe
  import zap_tag_ram_ctrl_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             adv,
  input  logic             acc,
  input  logic [IDX_W-1:0] lkp_idx,
  input  logic [TAG_W-1:0] lkp_tag,
  input  logic [IDX_W-1:0] wr_idx,
  output logic             s1_v,
  output logic             s2_v,
  output logic [TAG_W-1:0] s2_tag,
  output logic             wr_inflight
);

  stage_t s1_r;
  stage_t s2_r;

  // Shift the stages in lockstep with the RAM, hold while it is stalled.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_r <= '0;
      s2_r <= '0;
    end else if (adv) begin
      s1_r <= '{v: acc, idx: lkp_idx, tag: lkp_tag};
      s2_r <= s1_r;
    end else begin
      s1_r <= s1_r;
      s2_r <= s2_r;
    end
  end

  assign s1_v        = s1_r.v;
  assign s2_v        = s2_r.v;
  assign s2_tag      = s2_r.tag;
  assign wr_inflight = (s1_r.v & (s1_r.idx == wr_idx)) |
                       (s2_r.v & (s2_r.idx == wr_idx));

endmodule

// File: rtl/zap_tag_ram_ctrl.sv
// Arbiter for the shared tag RAM: lookup/refill grants with index hazard
// checks, result back-pressure via clock enable, and drain-then-clear.
module zap_tag_ram_ctrl
  import zap_tag_ram_ctrl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset_n,
  zap_tag_ram_ctrl_if.slave bus
);

  state_t           state_r;
  state_t           state_nxt;
  logic             ram_inv_r;
  logic             inv_ack_r;
  logic             adv;
  logic             grant_ok;
  logic             wr_ok;
  logic             lkp_ok;
  logic             wr_inflight;
  logic             s1_v;
  logic             s2_v;
  logic [TAG_W-1:0] s2_tag;
  ram_word_t        rd_word;

  zap_tag_ram_ctrl_pipe u_pipe (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .adv         (adv),
    .acc         (lkp_ok),
    .lkp_idx     (bus.i_lkp_idx),
    .lkp_tag     (bus.i_lkp_tag),
    .wr_idx      (bus.i_wr_idx),
    .s1_v        (s1_v),
    .s2_v        (s2_v),
    .s2_tag      (s2_tag),
    .wr_inflight (wr_inflight)
  );

  assign adv      = !s2_v | bus.i_res_ready;
  assign grant_ok = adv & (state_r == RUN) & !bus.i_inv_req;
  assign wr_ok    = bus.i_wr_valid & grant_ok & !wr_inflight;
  // A same-index refill wins so the retried lookup observes the new entry.
  assign lkp_ok   = bus.i_lkp_valid & grant_ok & !(wr_ok & (bus.i_wr_idx == bus.i_lkp_idx));

  assign bus.o_wr_ready  = wr_ok;
  assign bus.o_lkp_ready = lkp_ok;
  assign bus.o_ram_clken = adv;
  assign bus.o_ram_wen   = wr_ok;
  assign bus.o_ram_waddr = bus.i_wr_idx;
  assign bus.o_ram_wdata = {bus.i_wr_tag, bus.i_wr_data};
  assign bus.o_ram_raddr = bus.i_lkp_idx;
  assign bus.o_ram_inv   = ram_inv_r;
  assign bus.o_inv_ack   = inv_ack_r;

  assign rd_word         = split_word(bus.i_ram_rdata);
  assign bus.o_res_valid = s2_v;
  assign bus.o_res_hit   = s2_v & bus.i_ram_rdav & (rd_word.tag == s2_tag);
  assign bus.o_res_data  = rd_word.data;

  // Invalidate sequencing: stop granting, wait for the pipe to empty, clear, acknowledge.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      RUN: begin
        if (bus.i_inv_req) state_nxt = DRAIN;
        else               state_nxt = RUN;
      end
      DRAIN: begin
        if (!s1_v && !s2_v) state_nxt = CLR;
        else                state_nxt = DRAIN;
      end
      CLR:     state_nxt = ACK;
      ACK:     state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // State register with RAM clear and ack decoded from the next state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r   <= RUN;
      ram_inv_r <= 1'b0;
      inv_ack_r <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      ram_inv_r <= (state_nxt == CLR);
      inv_ack_r <= (state_nxt == ACK);
    end
  end

endmodule

// File: doc/zap_tag_ram_ctrl.md
Name: zap_tag_ram_ctrl

Overview:
- Controller and arbiter in front of the single-cycle-clear tag RAM (zap_mem_inv_block) used by the TLBs.
- Shares the RAM between three requesters: a lookup port (read + tag compare), a refill port (write) and an invalidate-all port.
- Tracks lookups through the RAM's 2-cycle read pipeline, resolves read/write index hazards, drains before clearing, and back-pressures with the RAM clock enable.

Parameters:
- DEPTH, 32, number of entries (power of 2); IDX_W = $clog2(DEPTH).
- TAG_W, 20, stored/compared tag width.
- DATA_W, 32, payload width. RAM WIDTH = TAG_W+DATA_W, with the tag in the MSBs.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_lkp_valid  in  1  lookup request.
- o_lkp_ready  out  1  lookup accepted this cycle.
- i_lkp_idx  in  IDX_W  lookup index.
- i_lkp_tag  in  TAG_W  tag to compare.
- i_wr_valid  in  1  refill write request.
- o_wr_ready  out  1  write accepted this cycle.
- i_wr_idx  in  IDX_W  write index.
- i_wr_tag  in  TAG_W  write tag.
- i_wr_data  in  DATA_W  write payload.
- i_inv_req  in  1  invalidate-all request, level.
- o_inv_ack  out  1  one-cycle completion pulse.
- o_res_valid  out  1  lookup result valid.
- i_res_ready  in  1  result consumed.
- o_res_hit  out  1  entry valid and tag match.
- o_res_data  out  DATA_W  payload from the RAM.
- o_ram_clken, o_ram_wen, o_ram_inv  out  1  RAM controls.
- o_ram_raddr, o_ram_waddr  out  IDX_W  RAM addresses.
- o_ram_wdata  out  TAG_W+DATA_W  {tag,data}.
- i_ram_rdata  in  TAG_W+DATA_W  RAM o_rdata.
- i_ram_rdav  in  1  RAM o_rdav.

Behaviour:
- Reset (async, active-low): FSM=RUN; s1_v=s2_v=0; o_inv_ack=0; o_ram_inv=0. Derived outputs follow: o_res_valid=0, o_ram_clken=1, o_ram_wen=0.
- Pipeline registers: s1 (v, idx, tag) and s2 (v, idx, tag), aligned with the RAM read latency of 2 enabled cycles.
- adv = !s2_v | i_res_ready. o_ram_clken = adv. When adv=0, all pipeline registers and the RAM hold.
- Result outputs (combinational from s2 and RAM):
  - o_res_valid = s2_v.
  - o_res_hit = s2_v & i_ram_rdav & (i_ram_rdata[MSB tag field] == s2_tag).
  - o_res_data = i_ram_rdata[DATA_W-1:0].
  - o_res_data and o_res_hit are held stable while o_res_valid & !i_res_ready.
- Write grant: o_wr_ready = i_wr_valid & adv & FSM==RUN & !i_inv_req & no in-flight index match, where in-flight match is (s1_v & s1_idx==i_wr_idx) | (s2_v & s2_idx==i_wr_idx).
- Write drive: o_ram_wen = o_wr_ready; o_ram_waddr = i_wr_idx; o_ram_wdata = {i_wr_tag, i_wr_data}.
- Lookup grant: o_lkp_ready = i_lkp_valid & adv & FSM==RUN & !i_inv_req & !(o_wr_ready & i_wr_idx==i_lkp_idx).
  - Same-cycle same-index conflict: the write wins and the lookup retries next cycle, so it observes the new entry.
- Lookup drive: o_ram_raddr = i_lkp_idx every cycle.
- Pipeline shift when adv: s1 <= {o_lkp_ready, i_lkp_idx, i_lkp_tag}; s2 <= s1.
- Ordering guarantee: a lookup always returns the RAM contents as of its acceptance cycle. Writes never overtake or undercut an in-flight lookup of the same index.
- Result latency: 2 cycles from lookup acceptance to o_res_valid with no back-pressure; throughput 1 lookup/cycle.
- FSM states RUN, DRAIN, CLR, ACK:
  - RUN -> DRAIN when i_inv_req=1. No new grants from that cycle on.
  - DRAIN -> CLR when s1_v=0 & s2_v=0. In-flight results still complete and need i_res_ready.
  - CLR: o_ram_inv=1 for exactly one cycle -> ACK.
  - ACK: o_inv_ack=1 for one cycle -> RUN.
- o_ram_inv and o_inv_ack are registered, decoded from the next state.
- Requester contract: drop i_inv_req in the cycle after o_inv_ack. If it is still high in RUN, a new invalidate sequence starts; this is legal.
- Empty pipeline at request: RUN -> DRAIN -> CLR -> ACK. Clear occurs 2 cycles after request; ack follows 1 cycle later.
- Writes and lookups in the CLR cycle are impossible because grants are gated by FSM.

Decomposition:
- Package zap_tag_ram_ctrl_pkg holds: the FSM enum (RUN, DRAIN, CLR, ACK); a packed struct for the pipeline stage {v, idx, tag}; and a function splitting RAM words into tag and data.
- One natural sub-module: zap_tag_ram_ctrl_pipe, the 2-stage s1/s2 tracker with adv hold and index-match outputs. The FSM and grant logic stay in the top.

Test Plan:
- Write idx 5 {tag 0x12345, data 0xCAFE0001}; lookup idx 5 tag 0x12345 two cycles later -> o_res_valid two cycles after grant, hit=1, data 0xCAFE0001. Same lookup with tag 0x00001 -> hit=0.
- Same-cycle write and lookup, both idx 3, tag 0xABCDE -> o_wr_ready=1, o_lkp_ready=0. Lookup granted next cycle and returns hit=1 with the new data.
- Lookup idx 7 in flight (s1), write idx 7 presented -> o_wr_ready=0 until s2 clears. The lookup returns the old contents (hit=0 after reset).
- Hold i_res_ready=0 with 2 lookups outstanding -> o_ram_clken=0, result stable for 4 cycles, no grants. Release -> both results delivered in order on consecutive cycles.
- Fill idx 0..3, then assert i_inv_req with 2 lookups in flight -> both results delivered; o_ram_inv one cycle; o_inv_ack next cycle. A following lookup of idx 0 returns hit=0.
- Drop i_reset_n mid-drain -> all outputs at reset values asynchronously; after release, FSM=RUN and the first lookup is granted immediately.
